// File: rtl/ex_stage_param_if.sv
// Issue bundle, forwarding controls and EX/MEM register outputs of ex_stage_param.
// master drives the bundle (issue side), slave is the execute stage.
interface ex_stage_param_if #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 3,
  parameter int NUM_FWD = 3
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                alu_op;
  logic                      alu_src_b;
  logic                      alu_reg_write;
  logic [RA_W-1:0]           alu_rd;
  logic [DATA_W-1:0]         alu_rn_val;
  logic [DATA_W-1:0]         alu_rm_val;
  logic [DATA_W-1:0]         alu_imm;
  logic                      mem_read;
  logic                      mem_write;
  logic                      mem_reg_write;
  logic [RA_W-1:0]           mem_rd;
  logic [DATA_W-1:0]         mem_rn_val;
  logic [DATA_W-1:0]         mem_rd_val;
  logic [DATA_W-1:0]         mem_imm;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [SEL_W-1:0]          fwd_alu_rn_sel;
  logic [SEL_W-1:0]          fwd_alu_rm_sel;
  logic [SEL_W-1:0]          fwd_mem_rn_sel;
  logic [SEL_W-1:0]          fwd_mem_rd_sel;
  logic                      out_stall;
  logic                      flush;

  logic                      p3_valid;
  logic                      p3_alu_reg_write;
  logic [RA_W-1:0]           p3_alu_rd;
  logic [DATA_W-1:0]         p3_alu_out;
  logic [3:0]                p3_flags;
  logic                      p3_mem_read;
  logic                      p3_mem_write;
  logic                      p3_mem_reg_write;
  logic [RA_W-1:0]           p3_mem_rd;
  logic [DATA_W-1:0]         p3_mem_addr;
  logic [DATA_W-1:0]         p3_mem_wdata;

  modport master (
    output in_valid, alu_op, alu_src_b, alu_reg_write, alu_rd,
           alu_rn_val, alu_rm_val, alu_imm,
           mem_read, mem_write, mem_reg_write, mem_rd,
           mem_rn_val, mem_rd_val, mem_imm,
           fwd_data, fwd_alu_rn_sel, fwd_alu_rm_sel, fwd_mem_rn_sel, fwd_mem_rd_sel,
           out_stall, flush,
    input  in_ready, p3_valid, p3_alu_reg_write, p3_alu_rd, p3_alu_out, p3_flags,
           p3_mem_read, p3_mem_write, p3_mem_reg_write, p3_mem_rd,
           p3_mem_addr, p3_mem_wdata
  );

  modport slave (
    input  in_valid, alu_op, alu_src_b, alu_reg_write, alu_rd,
           alu_rn_val, alu_rm_val, alu_imm,
           mem_read, mem_write, mem_reg_write, mem_rd,
           mem_rn_val, mem_rd_val, mem_imm,
           fwd_data, fwd_alu_rn_sel, fwd_alu_rm_sel, fwd_mem_rn_sel, fwd_mem_rd_sel,
           out_stall, flush,
    output in_ready, p3_valid, p3_alu_reg_write, p3_alu_rd, p3_alu_out, p3_flags,
           p3_mem_read, p3_mem_write, p3_mem_reg_write, p3_mem_rd,
           p3_mem_addr, p3_mem_wdata
  );
endinterface

// File: rtl/ex_stage_param.sv
// Dual-slot (ALU + MEM) execute stage with operand forwarding and an EX/MEM output register.
// Define VLIW_EX_MUL_EN for the multi-cycle shift-add MUL; otherwise opcode 111 yields 0 in one cycle.
//
// state | meaning
// IDLE  | accepting bundles; single-cycle ops complete from here
// BUSY  | shift-add MUL in progress, one step per cycle
// DONE  | MUL product ready, waiting for downstream to take it
module ex_stage_param #(
  parameter int DATA_W  = 32,
  parameter int RA_W    = 3,
  parameter int NUM_FWD = 3
) (
  input logic             clk,
  input logic             reset,
  ex_stage_param_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int M     = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Selector values above NUM_FWD fall through to the register value.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [SEL_W-1:0]          sel,
    input logic [DATA_W-1:0]         reg_val,
    input logic [NUM_FWD*DATA_W-1:0] fwd
  );
    logic [DATA_W-1:0] r;
    r = reg_val;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (int'(sel) == k + 1) r = fwd[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  logic              p3_valid_q, p3_alu_reg_write_q;
  logic              p3_mem_read_q, p3_mem_write_q, p3_mem_reg_write_q;
  logic [RA_W-1:0]   p3_alu_rd_q, p3_mem_rd_q;
  logic [DATA_W-1:0] p3_alu_out_q, p3_mem_addr_q, p3_mem_wdata_q;
  logic [3:0]        p3_flags_q;

  logic [DATA_W-1:0] op_a, rm_val, op_b, mem_base;
  logic [DATA_W-1:0] alu_res_d, mem_addr_d, mem_wdata_d;
  logic [DATA_W:0]   sum_x, diff_x;
  logic              c_d, v_d;
  logic [3:0]        flags_d;
  logic              accept;
  state_e            state_q;

  always_comb begin
    op_a        = resolve(bus.fwd_alu_rn_sel, bus.alu_rn_val, bus.fwd_data);
    rm_val      = resolve(bus.fwd_alu_rm_sel, bus.alu_rm_val, bus.fwd_data);
    op_b        = bus.alu_src_b ? bus.alu_imm : rm_val;
    mem_base    = resolve(bus.fwd_mem_rn_sel, bus.mem_rn_val, bus.fwd_data);
    mem_wdata_d = resolve(bus.fwd_mem_rd_sel, bus.mem_rd_val, bus.fwd_data);
    mem_addr_d  = mem_base + bus.mem_imm;
    sum_x       = {1'b0, op_a} + {1'b0, op_b};
    diff_x      = {1'b0, op_a} - {1'b0, op_b};
    alu_res_d   = '0;
    c_d         = 1'b0;
    v_d         = 1'b0;
    case (bus.alu_op)
      3'b000: begin
        alu_res_d = sum_x[M:0];
        c_d       = sum_x[DATA_W];
        v_d       = (op_a[M] == op_b[M]) && (sum_x[M] != op_a[M]);
      end
      3'b001: begin
        alu_res_d = diff_x[M:0];
        c_d       = ~diff_x[DATA_W];
        v_d       = (op_a[M] != op_b[M]) && (diff_x[M] != op_a[M]);
      end
      3'b010:  alu_res_d = op_a & op_b;
      3'b011:  alu_res_d = op_a | op_b;
      3'b100:  alu_res_d = op_a ^ op_b;
      3'b101:  alu_res_d = op_a << op_b[SH_W-1:0];
      3'b110:  alu_res_d = op_a >> op_b[SH_W-1:0];
      default: alu_res_d = '0;  // MUL: sequenced below, or stubbed to zero
    endcase
    flags_d = {alu_res_d == '0, alu_res_d[M], c_d, v_d};
  end

  assign bus.in_ready = ~bus.out_stall & (state_q == IDLE);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;

`ifdef VLIW_EX_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0]  step_cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, prod_q;
  logic              hold_alu_reg_write_q, hold_mem_read_q, hold_mem_write_q, hold_mem_reg_write_q;
  logic [RA_W-1:0]   hold_alu_rd_q, hold_mem_rd_q;
  logic [DATA_W-1:0] hold_mem_addr_q, hold_mem_wdata_q;
  logic              is_mul;

  assign is_mul = (bus.alu_op == 3'b111);
`else
  assign state_q = IDLE;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p3_valid_q         <= 1'b0;
      p3_alu_reg_write_q <= 1'b0;
      p3_alu_rd_q        <= '0;
      p3_alu_out_q       <= '0;
      p3_flags_q         <= '0;
      p3_mem_read_q      <= 1'b0;
      p3_mem_write_q     <= 1'b0;
      p3_mem_reg_write_q <= 1'b0;
      p3_mem_rd_q        <= '0;
      p3_mem_addr_q      <= '0;
      p3_mem_wdata_q     <= '0;
`ifdef VLIW_EX_MUL_EN
      state_q              <= IDLE;
      step_cnt_q           <= '0;
      mcand_q              <= '0;
      mplier_q             <= '0;
      prod_q               <= '0;
      hold_alu_reg_write_q <= 1'b0;
      hold_alu_rd_q        <= '0;
      hold_mem_read_q      <= 1'b0;
      hold_mem_write_q     <= 1'b0;
      hold_mem_reg_write_q <= 1'b0;
      hold_mem_rd_q        <= '0;
      hold_mem_addr_q      <= '0;
      hold_mem_wdata_q     <= '0;
`endif
    end else if (bus.flush) begin
      p3_valid_q <= 1'b0;
`ifdef VLIW_EX_MUL_EN
      state_q <= IDLE;
`endif
    end else begin
`ifdef VLIW_EX_MUL_EN
      if (state_q == BUSY) begin
        // Stepping continues under out_stall; only DONE waits for downstream.
        if (mplier_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (step_cnt_q == '0) state_q <= DONE;
        else                  step_cnt_q <= step_cnt_q - CNT_W'(1);
        if (!bus.out_stall) p3_valid_q <= 1'b0;
      end else if (state_q == DONE) begin
        if (!bus.out_stall) begin
          p3_valid_q         <= 1'b1;
          p3_alu_out_q       <= prod_q;
          p3_flags_q         <= {prod_q == '0, prod_q[M], 2'b00};
          p3_alu_reg_write_q <= hold_alu_reg_write_q;
          p3_alu_rd_q        <= hold_alu_rd_q;
          p3_mem_read_q      <= hold_mem_read_q;
          p3_mem_write_q     <= hold_mem_write_q;
          p3_mem_reg_write_q <= hold_mem_reg_write_q;
          p3_mem_rd_q        <= hold_mem_rd_q;
          p3_mem_addr_q      <= hold_mem_addr_q;
          p3_mem_wdata_q     <= hold_mem_wdata_q;
          state_q            <= IDLE;
        end
      end else if (accept && is_mul) begin
        state_q              <= BUSY;
        step_cnt_q           <= CNT_W'(DATA_W - 1);
        mcand_q              <= op_a;
        mplier_q             <= op_b;
        prod_q               <= '0;
        hold_alu_reg_write_q <= bus.alu_reg_write;
        hold_alu_rd_q        <= bus.alu_rd;
        hold_mem_read_q      <= bus.mem_read;
        hold_mem_write_q     <= bus.mem_write;
        hold_mem_reg_write_q <= bus.mem_reg_write;
        hold_mem_rd_q        <= bus.mem_rd;
        hold_mem_addr_q      <= mem_addr_d;
        hold_mem_wdata_q     <= mem_wdata_d;
        p3_valid_q           <= 1'b0;
      end else
`endif
      if (accept) begin
        p3_valid_q         <= 1'b1;
        p3_alu_out_q       <= alu_res_d;
        p3_flags_q         <= flags_d;
        p3_alu_reg_write_q <= bus.alu_reg_write;
        p3_alu_rd_q        <= bus.alu_rd;
        p3_mem_read_q      <= bus.mem_read;
        p3_mem_write_q     <= bus.mem_write;
        p3_mem_reg_write_q <= bus.mem_reg_write;
        p3_mem_rd_q        <= bus.mem_rd;
        p3_mem_addr_q      <= mem_addr_d;
        p3_mem_wdata_q     <= mem_wdata_d;
      end else if (!bus.out_stall) begin
        p3_valid_q <= 1'b0;
      end
    end
  end

  assign bus.p3_valid         = p3_valid_q;
  assign bus.p3_alu_reg_write = p3_alu_reg_write_q;
  assign bus.p3_alu_rd        = p3_alu_rd_q;
  assign bus.p3_alu_out       = p3_alu_out_q;
  assign bus.p3_flags         = p3_flags_q;
  assign bus.p3_mem_read      = p3_mem_read_q;
  assign bus.p3_mem_write     = p3_mem_write_q;
  assign bus.p3_mem_reg_write = p3_mem_reg_write_q;
  assign bus.p3_mem_rd        = p3_mem_rd_q;
  assign bus.p3_mem_addr      = p3_mem_addr_q;
  assign bus.p3_mem_wdata     = p3_mem_wdata_q;
endmodule

// File: tb/tb_ex_stage_param.sv
// Bench for ex_stage_param: directed literal cases plus random bundles checked every cycle
// against a transaction-level model (countdown for MUL latency, native arithmetic for results).
module tb_ex_stage_param;
  localparam int DW = 32;
  localparam int RW = 3;
  localparam int NF = 3;
`ifdef VLIW_EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ex_stage_param_if #(.DATA_W(DW), .RA_W(RW), .NUM_FWD(NF)) bus ();
  ex_stage_param #(.DATA_W(DW), .RA_W(RW), .NUM_FWD(NF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic          arw;
    logic [RW-1:0] ard;
    logic [DW-1:0] aout;
    logic [3:0]    flags;
    logic          mr, mw, mrw;
    logic [RW-1:0] mrd;
    logic [DW-1:0] maddr, mwdata;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_busy  = 1'b0;
  int   m_wait  = 0;
  res_t m_out   = '0;
  res_t m_pend  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] r);
    if (sel >= 2'd1 && int'(sel) <= NF) return bus.fwd_data[(int'(sel)-1)*DW +: DW];
    return r;
  endfunction

  function automatic res_t compute();
    res_t        r;
    logic [DW-1:0] a, b, y;
    logic [63:0] ua, ub, wide;
    longint      sa, sb, s;
    bit          c, v;
    a  = pick(bus.fwd_alu_rn_sel, bus.alu_rn_val);
    b  = bus.alu_src_b ? bus.alu_imm : pick(bus.fwd_alu_rm_sel, bus.alu_rm_val);
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    y  = '0;
    case (bus.alu_op)
      3'd0: begin
        wide = ua + ub; y = wide[31:0]; c = (wide >= 64'h1_0000_0000);
        s = sa + sb; v = (s != longint'($signed(y)));
      end
      3'd1: begin
        y = a - b; c = (a >= b);
        s = sa - sb; v = (s != longint'($signed(y)));
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = a << b[4:0];
      3'd6: y = a >> b[4:0];
      default: begin wide = ua * ub; y = MUL_EN ? wide[31:0] : 32'd0; end
    endcase
    r.aout   = y;
    r.flags  = {y == 32'd0, y[31], c, v};
    r.arw    = bus.alu_reg_write;
    r.ard    = bus.alu_rd;
    r.mr     = bus.mem_read;
    r.mw     = bus.mem_write;
    r.mrw    = bus.mem_reg_write;
    r.mrd    = bus.mem_rd;
    r.maddr  = pick(bus.fwd_mem_rn_sel, bus.mem_rn_val) + bus.mem_imm;
    r.mwdata = pick(bus.fwd_mem_rd_sel, bus.mem_rd_val);
    return r;
  endfunction

  // Reference model: one transaction per edge, MUL modelled as a cycle countdown.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0; m_busy = 1'b0; m_wait = 0; m_out = '0; m_pend = '0;
    end else begin
      bit acc;
      acc = bus.in_valid && !bus.out_stall && !m_busy && !bus.flush;
      if (bus.flush) begin
        m_valid = 1'b0; m_busy = 1'b0;
      end else if (m_busy) begin
        if (m_wait > 0) begin
          m_wait--;
          if (!bus.out_stall) m_valid = 1'b0;
        end else if (!bus.out_stall) begin
          m_out = m_pend; m_valid = 1'b1; m_busy = 1'b0;
        end
      end else if (acc) begin
        if (MUL_EN && bus.alu_op == 3'd7) begin
          m_pend = compute(); m_busy = 1'b1; m_wait = DW; m_valid = 1'b0;
        end else begin
          m_out = compute(); m_valid = 1'b1;
        end
      end else if (!bus.out_stall) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("cyc p3_valid", bus.p3_valid, m_valid);
      chk("cyc in_ready", bus.in_ready, !bus.out_stall && !m_busy);
      chk("cyc alu_out", bus.p3_alu_out, m_out.aout);
      chk("cyc flags", bus.p3_flags, m_out.flags);
      chk("cyc mem_addr", bus.p3_mem_addr, m_out.maddr);
      chk("cyc mem_wdata", bus.p3_mem_wdata, m_out.mwdata);
      chk("cyc ctrl", {bus.p3_alu_reg_write, bus.p3_alu_rd, bus.p3_mem_read, bus.p3_mem_write,
                       bus.p3_mem_reg_write, bus.p3_mem_rd},
                      {m_out.arw, m_out.ard, m_out.mr, m_out.mw, m_out.mrw, m_out.mrd});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_in();
    bus.in_valid = 1'b0; bus.alu_op = 3'd0; bus.alu_src_b = 1'b0; bus.alu_reg_write = 1'b0;
    bus.alu_rd = '0; bus.alu_rn_val = '0; bus.alu_rm_val = '0; bus.alu_imm = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_reg_write = 1'b0; bus.mem_rd = '0;
    bus.mem_rn_val = '0; bus.mem_rd_val = '0; bus.mem_imm = '0; bus.fwd_data = '0;
    bus.fwd_alu_rn_sel = '0; bus.fwd_alu_rm_sel = '0; bus.fwd_mem_rn_sel = '0;
    bus.fwd_mem_rd_sel = '0; bus.out_stall = 1'b0; bus.flush = 1'b0;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h1;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_in();
    bus.in_valid      = ($urandom_range(0, 9) < 7);
    bus.alu_op        = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
    bus.alu_src_b     = 1'($urandom_range(0, 1));
    bus.alu_reg_write = 1'($urandom_range(0, 1));
    bus.alu_rd        = 3'($urandom_range(0, 7));
    bus.alu_rn_val    = rval();
    bus.alu_rm_val    = rval();
    bus.alu_imm       = rval();
    bus.mem_read      = 1'($urandom_range(0, 1));
    bus.mem_write     = 1'($urandom_range(0, 1));
    bus.mem_reg_write = 1'($urandom_range(0, 1));
    bus.mem_rd        = 3'($urandom_range(0, 7));
    bus.mem_rn_val    = rval();
    bus.mem_rd_val    = rval();
    bus.mem_imm       = rval();
    bus.fwd_data      = {rval(), rval(), rval()};
    bus.fwd_alu_rn_sel = 2'($urandom_range(0, 3));
    bus.fwd_alu_rm_sel = 2'($urandom_range(0, 3));
    bus.fwd_mem_rn_sel = 2'($urandom_range(0, 3));
    bus.fwd_mem_rd_sel = 2'($urandom_range(0, 3));
    bus.out_stall     = ($urandom_range(0, 4) == 0);
    bus.flush         = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    reset = 1'b0;
    repeat (2) step();
    chk("reset p3_valid", bus.p3_valid, 0);
    chk("reset alu_out", bus.p3_alu_out, 0);
    chk("reset flags", bus.p3_flags, 0);
    chk("reset mem_addr", bus.p3_mem_addr, 0);
    chk("reset in_ready", bus.in_ready, 1);
    #2 reset = 1'b1;
    chk_en = 1'b1;
    step();

    // signed overflow on ADD
    clear_in();
    bus.alu_rn_val = 32'h7FFF_FFFF; bus.alu_rm_val = 32'h1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("add ovf out", bus.p3_alu_out, 32'h8000_0000);
    chk("add ovf flags", bus.p3_flags, 4'b0101);
    chk("add ovf valid", bus.p3_valid, 1);

    // forwarded rn + immediate, MEM address wrap
    clear_in();
    bus.fwd_data[63:32] = 32'h10; bus.fwd_alu_rn_sel = 2'd2; bus.alu_rn_val = 32'h99;
    bus.alu_imm = 32'h4; bus.alu_src_b = 1'b1; bus.alu_reg_write = 1'b1; bus.alu_rd = 3'd5;
    bus.mem_rn_val = 32'hFFFF_FFFC; bus.mem_imm = 32'h8; bus.mem_rd_val = 32'hA5A5_F00F;
    bus.mem_write = 1'b1; bus.in_valid = 1'b1;
    step();
    chk("fwd alu_out", bus.p3_alu_out, 32'h14);
    chk("fwd alu_rd", bus.p3_alu_rd, 3'd5);
    chk("mem addr wrap", bus.p3_mem_addr, 32'h4);
    chk("mem wdata", bus.p3_mem_wdata, 32'hA5A5_F00F);

    // hold under stall with a SUB waiting
    clear_in();
    bus.alu_op = 3'd1; bus.alu_rn_val = 32'd3; bus.alu_rm_val = 32'd5; bus.in_valid = 1'b1;
    bus.out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall hold out", bus.p3_alu_out, 32'h14);
      chk("stall hold valid", bus.p3_valid, 1);
      chk("stall in_ready", bus.in_ready, 0);
    end
    bus.out_stall = 1'b0;
    step();
    chk("sub neg out", bus.p3_alu_out, 32'hFFFF_FFFE);
    chk("sub neg flags", bus.p3_flags, 4'b0100);
    bus.alu_rn_val = 32'd5; bus.alu_rm_val = 32'd3;
    step();
    bus.in_valid = 1'b0;
    chk("sub pos out", bus.p3_alu_out, 32'h2);
    chk("sub pos flags", bus.p3_flags, 4'b0010);

    // MUL 7*6
    clear_in();
    bus.alu_op = 3'd7; bus.alu_rn_val = 32'd7; bus.alu_rm_val = 32'd6; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
`ifdef VLIW_EX_MUL_EN
    begin
      int edges;
      bit ready_low;
      edges = 0;
      ready_low = 1'b1;
      while (!bus.p3_valid && edges < 100) begin
        if (bus.in_ready) ready_low = 1'b0;
        step();
        edges++;
      end
      chk("mul edges", edges, 33);
      chk("mul ready low", ready_low, 1);
      chk("mul out", bus.p3_alu_out, 32'd42);
      chk("mul flags", bus.p3_flags, 4'b0000);
    end
    // flush while BUSY
    bus.alu_rn_val = 32'd3; bus.alu_rm_val = 32'd5; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("mul flush valid", bus.p3_valid, 0);
    chk("mul flush ready", bus.in_ready, 1);
    repeat (40) step();
`else
    chk("mul stub out", bus.p3_alu_out, 32'd0);
    chk("mul stub flags", bus.p3_flags, 4'b1000);
    chk("mul stub valid", bus.p3_valid, 1);
`endif

    // flush kills a same-cycle bundle
    clear_in();
    bus.alu_rn_val = 32'd1; bus.alu_rm_val = 32'd1; bus.in_valid = 1'b1; bus.flush = 1'b1;
    step();
    clear_in();
    chk("flush bundle valid", bus.p3_valid, 0);
    chk("flush bundle ready", bus.in_ready, 1);

    // async reset mid-operation
    bus.alu_op = 3'd7; bus.alu_rn_val = 32'd9; bus.alu_rm_val = 32'd9;
    bus.mem_rn_val = 32'h1234; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    #1;
    chk("async rst valid", bus.p3_valid, 0);
    chk("async rst mem_addr", bus.p3_mem_addr, 0);
    chk("async rst ready", bus.in_ready, 1);
    #1 reset = 1'b1;
    repeat (40) step();

    for (int i = 0; i < 800; i++) begin
      rand_in();
      step();
    end
    clear_in();
    repeat (40) step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
